// File: rtl/ex_muldiv_sequencer_if.sv
// Handshake and operand/result bundle between the EX stage and the
// multi-cycle RV32M unit. The pipeline side drives through the master
// modport; the execution unit sits on the slave modport.
interface ex_muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3_in;
  logic [XLEN-1:0] op_a_in;
  logic [XLEN-1:0] op_b_in;
  logic [4:0]      reg_rd_in;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result_out;
  logic [4:0]      reg_rd_out;

  modport master (
    output start, flush, funct3_in, op_a_in, op_b_in, reg_rd_in,
    input  stall, busy, done, result_out, reg_rd_out
  );

  modport slave (
    input  start, flush, funct3_in, op_a_in, op_b_in, reg_rd_in,
    output stall, busy, done, result_out, reg_rd_out
  );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M execution unit for the EX stage. Multiplies by
// shift-add and divides by restoring division, one bit per cycle, on
// operand magnitudes; signs are reapplied at the end. Divide-by-zero and
// signed overflow are answered directly from the start cycle. The
// pipeline is stalled from the accepting cycle until the result is ready.
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic                  clock,
  input logic                  reset,
  ex_muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_counter;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_a_abs;
  logic [XLEN-1:0]   r_b_abs;
  logic              r_neg_res;   // product / quotient must be negated
  logic              r_neg_rem;   // remainder takes the dividend's sign
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] r_acc;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  // Start-cycle operand decode (signedness, magnitudes, special cases)
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_abs, w_b_abs;
  logic            w_div_zero, w_div_ovf;
  logic [XLEN-1:0] w_special_result;

  // Per-iteration datapath
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift, w_div_diff;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_final;

  // Decode of the incoming M-op; only meaningful while accepting in IDLE
  always_comb begin
    w_a_signed = (bus.funct3_in == 3'b001) || (bus.funct3_in == 3'b010) ||
                 (bus.funct3_in == 3'b100) || (bus.funct3_in == 3'b110);
    w_b_signed = (bus.funct3_in == 3'b001) || (bus.funct3_in == 3'b100) ||
                 (bus.funct3_in == 3'b110);
    w_a_neg    = w_a_signed && bus.op_a_in[XLEN-1];
    w_b_neg    = w_b_signed && bus.op_b_in[XLEN-1];
    w_a_abs    = w_a_neg ? (~bus.op_a_in + 1'b1) : bus.op_a_in;
    w_b_abs    = w_b_neg ? (~bus.op_b_in + 1'b1) : bus.op_b_in;
    w_div_zero = bus.funct3_in[2] && (bus.op_b_in == '0);
    w_div_ovf  = bus.funct3_in[2] && !bus.funct3_in[0] &&
                 (bus.op_a_in == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (bus.op_b_in == '1);
    w_special_result = '0;
    if (w_div_zero)
      w_special_result = bus.funct3_in[1] ? bus.op_a_in : '1;
    else if (w_div_ovf)
      w_special_result = bus.funct3_in[1] ? '0 : bus.op_a_in;
  end

  // One shift-add / restoring-divide step and the final sign fix-up
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                  (r_acc[0] ? {1'b0, r_a_abs} : '0);
    w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, r_b_abs};
    w_div_ge    = !w_div_diff[XLEN];
    w_div_next  = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                   r_acc[XLEN-2:0], w_div_ge};
    w_prod      = r_neg_res ? (~w_mul_next + 1'b1) : w_mul_next;
    w_quot      = w_div_next[XLEN-1:0];
    w_rem       = w_div_next[2*XLEN-1:XLEN];
    if (!r_funct3[2])
      w_final = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else if (!r_funct3[1])
      w_final = r_neg_res ? (~w_quot + 1'b1) : w_quot;
    else
      w_final = r_neg_rem ? (~w_rem + 1'b1) : w_rem;
  end

  // Sequencer: accept in IDLE, iterate in CALC, publish result in DONE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_counter <= '0;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_a_abs   <= '0;
      r_b_abs   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state   <= S_IDLE;
        r_counter <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_funct3  <= bus.funct3_in;
              r_rd      <= bus.reg_rd_in;
              r_a_abs   <= w_a_abs;
              r_b_abs   <= w_b_abs;
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              r_counter <= '0;
              if (w_div_zero || w_div_ovf) begin
                r_result <= w_special_result;
                r_rd_out <= bus.reg_rd_in;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_acc   <= bus.funct3_in[2] ? {{XLEN{1'b0}}, w_a_abs}
                                            : {{XLEN{1'b0}}, w_b_abs};
                r_state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_acc     <= r_funct3[2] ? w_div_next : w_mul_next;
            r_counter <= r_counter + CW'(1);
            if (r_counter == CW'(XLEN-1)) begin
              r_counter <= '0;
              r_result  <= w_final;
              r_rd_out  <= r_rd;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.stall      = ((r_state == S_IDLE) && bus.start && !bus.flush) ||
                          (r_state == S_CALC);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.result_out = r_result;
  assign bus.reg_rd_out = r_rd_out;
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for the RV32M sequencer: scoreboard of expected
// results, latency and stall profile per M-op, plus flush/reset/back-to-back.
module tb_ex_muldiv_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ex_muldiv_sequencer_if #(.XLEN(32)) bus();
  ex_muldiv_sequencer #(.XLEN(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } txn_t;

  txn_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference arithmetic built from the language's own signed/unsigned ops
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb2, ua, ub, p;
    logic [31:0] r;
    logic ovf;
    sa = {{32{a[31]}}, a}; sb2 = {{32{b[31]}}, b};
    ua = {32'b0, a};       ub = {32'b0, b};
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    r = '0;
    case (f)
      3'd0: begin p = ua * ub;  r = p[31:0];  end
      3'd1: begin p = sa * sb2; r = p[63:32]; end
      3'd2: begin p = sa * ub;  r = p[63:32]; end
      3'd3: begin p = ua * ub;  r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
    return 33;
  endfunction

  // Wait for done from cycle 1 onward; counts stall-high cycles seen
  task automatic wait_done(output int lat, output int stall_hi, output bit to);
    lat = 1; stall_hi = 0; to = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.stall) stall_hi++;
      if (bus.done) break;
      if (lat >= 100) begin to = 1'b1; break; end
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.start = 1'b1; bus.funct3_in = f; bus.op_a_in = a; bus.op_b_in = b; bus.reg_rd_in = rd;
  endtask

  // Issue one M-op, wait for completion, return observations and the scoreboard entry
  task automatic exec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] res,
                      output txn_t e, output int lat, output int stall_hi, output logic stall0,
                      output bit to, output logic [31:0] got, output logic [4:0] got_rd);
    txn_t t;
    t.f = f; t.a = a; t.b = b; t.rd = rd; t.res = res; t.lat = exp_lat(f, a, b);
    sb.push_back(t);
    drive_start(f, a, b, rd);
    @(negedge clock); stall0 = bus.stall;
    @(posedge clock); #1; bus.start = 1'b0;
    wait_done(lat, stall_hi, to);
    got = bus.result_out; got_rd = bus.reg_rd_out;
    e = sb.pop_front();
    $display("txn f=%0d a=%h b=%h rd=%0d result=%h exp=%h lat=%0d", f, a, b, rd, got, e.res, lat);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.flush = 0; bus.funct3_in = 0; bus.op_a_in = 0; bus.op_b_in = 0; bus.reg_rd_in = 0;
    #1 reset = 1'b1;
    #2;
    checks++; if (bus.result_out !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result_out); end
    checks++; if (bus.reg_rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", bus.reg_rd_out); end
    checks++; if ({bus.stall, bus.busy, bus.done} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {bus.stall, bus.busy, bus.done}); end
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_mul();
    logic [2:0]  fv[4]; logic [31:0] av[4], bv[4], rv[4];
    logic [2:0] f; logic [31:0] a, b, r, got; logic [4:0] grd; logic s0;
    txn_t e; int lat, sh; bit to;
    fv = '{3'd0, 3'd1, 3'd3, 3'd2};
    av = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    bv = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2};
    rv = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin f = fv[i]; a = av[i]; b = bv[i]; r = rv[i]; end
      else begin f = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom; r = model(f, a, b); end
      exec(f, a, b, 5'(i + 1), r, e, lat, sh, s0, to, got, grd);
      checks++; if (to) begin failures++; $display("FAIL mul_timeout i=%0d got=no_done exp=done", i); end
      checks++; if (got !== e.res) begin failures++; $display("FAIL mul_result i=%0d got=%h exp=%h", i, got, e.res); end
      checks++; if (grd !== e.rd) begin failures++; $display("FAIL mul_rd i=%0d got=%0d exp=%0d", i, grd, e.rd); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL mul_latency i=%0d got=%0d exp=%0d", i, lat, e.lat); end
      checks++; if (s0 !== 1'b1 || sh !== e.lat - 1) begin failures++; $display("FAIL mul_stall i=%0d got=%b/%0d exp=1/%0d", i, s0, sh, e.lat - 1); end
    end
    // done is a single-cycle pulse; result holds afterwards
    @(negedge clock);
    checks++; if (bus.done !== 1'b0 || bus.result_out !== e.res) begin failures++; $display("FAIL mul_hold got=%b/%h exp=0/%h", bus.done, bus.result_out, e.res); end
    @(posedge clock); #1;
  endtask

  task automatic test_div();
    logic [2:0]  fv[3]; logic [31:0] av[3], bv[3], rv[3];
    logic [2:0] f; logic [31:0] a, b, r, got; logic [4:0] grd; logic s0;
    txn_t e; int lat, sh; bit to;
    fv = '{3'd4, 3'd6, 3'd5};
    av = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100};
    bv = '{32'd2, 32'd2, 32'd7};
    rv = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
    for (int i = 0; i < 9; i++) begin
      if (i < 3) begin f = fv[i]; a = av[i]; b = bv[i]; r = rv[i]; end
      else begin
        f = 3'($urandom_range(4, 7)); a = $urandom; b = $urandom >> $urandom_range(0, 28);
        if (b == 0) b = 32'd3;
        r = model(f, a, b);
      end
      exec(f, a, b, 5'(i + 10), r, e, lat, sh, s0, to, got, grd);
      checks++; if (to) begin failures++; $display("FAIL div_timeout i=%0d got=no_done exp=done", i); end
      checks++; if (got !== e.res) begin failures++; $display("FAIL div_result i=%0d got=%h exp=%h", i, got, e.res); end
      checks++; if (grd !== e.rd) begin failures++; $display("FAIL div_rd i=%0d got=%0d exp=%0d", i, grd, e.rd); end
      checks++; if (lat !== e.lat || sh !== e.lat - 1) begin failures++; $display("FAIL div_timing i=%0d got=%0d/%0d exp=%0d/%0d", i, lat, sh, e.lat, e.lat - 1); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fv[6]; logic [31:0] av[6], bv[6], rv[6];
    logic [31:0] got; logic [4:0] grd; logic s0;
    txn_t e; int lat, sh; bit to;
    fv = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    av = '{32'h12345678, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'd7};
    bv = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    rv = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd7};
    for (int i = 0; i < 6; i++) begin
      exec(fv[i], av[i], bv[i], 5'(i + 20), rv[i], e, lat, sh, s0, to, got, grd);
      checks++; if (got !== e.res) begin failures++; $display("FAIL special_result i=%0d got=%h exp=%h", i, got, e.res); end
      checks++; if (grd !== e.rd) begin failures++; $display("FAIL special_rd i=%0d got=%0d exp=%0d", i, grd, e.rd); end
      checks++; if (lat !== 1 || sh !== 0 || s0 !== 1'b1) begin failures++; $display("FAIL special_timing i=%0d got=lat%0d/stall%0d/%b exp=lat1/stall0/1", i, lat, sh, s0); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, got; logic [4:0] prev_rd, grd; logic s0;
    txn_t e, t; int lat, sh, seen; bit to;
    prev = bus.result_out; prev_rd = bus.reg_rd_out;
    t.f = 3'd0; t.a = 32'd9; t.b = 32'd9; t.rd = 5'd30; t.res = 32'd81; t.lat = 33;
    sb.push_back(t);
    drive_start(3'd0, 32'd9, 32'd9, 5'd30);          // cycle 0
    @(posedge clock); #1; bus.start = 1'b0;           // cycle 1
    repeat (9) @(posedge clock); #1;                  // cycle 10
    bus.flush = 1'b1;
    @(posedge clock); #1; bus.flush = 1'b0;           // cycle 11
    @(negedge clock);
    checks++; if ({bus.busy, bus.stall, bus.done} !== 3'b000) begin failures++; $display("FAIL flush_idle got=%b exp=000", {bus.busy, bus.stall, bus.done}); end
    void'(sb.pop_back());
    $display("txn flushed MUL rd=30 at cycle 10");
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clock); if (bus.done) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    checks++; if (bus.result_out !== prev || bus.reg_rd_out !== prev_rd) begin failures++; $display("FAIL flush_hold got=%h/%0d exp=%h/%0d", bus.result_out, bus.reg_rd_out, prev, prev_rd); end
    // flush wins over start in IDLE
    @(posedge clock); #1;
    drive_start(3'd5, 32'd50, 32'd5, 5'd29); bus.flush = 1'b1;
    @(negedge clock);
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_start_stall got=%b exp=0", bus.stall); end
    @(posedge clock); #1; bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", bus.busy); end
    @(posedge clock); #1;
    exec(3'd0, 32'd12, 32'd11, 5'd31, 32'd132, e, lat, sh, s0, to, got, grd);
    checks++; if (got !== e.res || grd !== e.rd || lat !== e.lat) begin failures++; $display("FAIL flush_recover got=%h/%0d/%0d exp=%h/%0d/%0d", got, grd, lat, e.res, e.rd, e.lat); end
  endtask

  task automatic test_reset_mid();
    txn_t t; int seen;
    t.f = 3'd5; t.a = 32'd1000; t.b = 32'd3; t.rd = 5'd12; t.res = 32'd333; t.lat = 33;
    sb.push_back(t);
    drive_start(3'd5, 32'd1000, 32'd3, 5'd12);
    @(posedge clock); #1; bus.start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.result_out !== 32'd0 || bus.reg_rd_out !== 5'd0) begin failures++; $display("FAIL midreset_data got=%h/%0d exp=0/0", bus.result_out, bus.reg_rd_out); end
    checks++; if ({bus.busy, bus.stall, bus.done} !== 3'b000) begin failures++; $display("FAIL midreset_ctl got=%b exp=000", {bus.busy, bus.stall, bus.done}); end
    void'(sb.pop_back());
    @(posedge clock); #1 reset = 1'b0;
    $display("txn reset during DIVU rd=12");
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clock); if (bus.done) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    txn_t t1, t2, e; int lat, sh; bit to;
    t1.f = 3'd0; t1.a = 32'd6;   t1.b = 32'd7; t1.rd = 5'd3; t1.res = 32'd42; t1.lat = 33;
    t2.f = 3'd7; t2.a = 32'd100; t2.b = 32'd9; t2.rd = 5'd9; t2.res = 32'd1;  t2.lat = 33;
    sb.push_back(t1); sb.push_back(t2);
    drive_start(t1.f, t1.a, t1.b, t1.rd);
    @(posedge clock); #1; bus.start = 1'b0;
    wait_done(lat, sh, to);
    e = sb.pop_front();
    $display("txn b2b first rd=%0d result=%h exp=%h lat=%0d", bus.reg_rd_out, bus.result_out, e.res, lat);
    checks++; if (to || bus.result_out !== e.res || bus.reg_rd_out !== e.rd) begin failures++; $display("FAIL b2b_first got=%h/%0d exp=%h/%0d", bus.result_out, bus.reg_rd_out, e.res, e.rd); end
    #1 drive_start(t2.f, t2.a, t2.b, t2.rd);         // start arrives during DONE
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.done !== 1'b1) begin failures++; $display("FAIL b2b_done_cycle got=%b/%b exp=0/1", bus.stall, bus.done); end
    @(posedge clock); #1;                              // IDLE: accepted here
    @(negedge clock);
    checks++; if (bus.stall !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b/%b exp=1/0", bus.stall, bus.busy); end
    @(posedge clock); #1; bus.start = 1'b0;
    wait_done(lat, sh, to);
    e = sb.pop_front();
    $display("txn b2b second rd=%0d result=%h exp=%h lat=%0d", bus.reg_rd_out, bus.result_out, e.res, lat);
    checks++; if (to || bus.result_out !== e.res || bus.reg_rd_out !== e.rd || lat !== e.lat) begin failures++; $display("FAIL b2b_second got=%h/%0d/%0d exp=%h/%0d/%0d", bus.result_out, bus.reg_rd_out, lat, e.res, e.rd, e.lat); end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
